// File: rtl/ram_lsu_ctrl_pkg.sv
// Shared definitions for the data-RAM load/store controller: funct3 codes, FSM states, request checks.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package ram_lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 inside {F3_B, F3_H, F3_W});
        end
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_lsu_ctrl_load_align.sv
// Load data aligner: moves the addressed byte/halfword to bit 0 and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none; the caller samples the result when RAM data is valid.
module ram_lsu_ctrl_load_align
    import ram_lsu_ctrl_pkg::*;
(
    input  logic [31:0] rd_data,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Shift the addressed lane down, then extend according to access size/signedness.
    always_comb begin
        shifted = rd_data >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/ram_lsu_ctrl.sv
// Single-outstanding load/store initiator for the byte-enabled synchronous data RAM.
// Latency accept->rsp_valid: error 1, store 2, load 2+RD_LATENCY cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module ram_lsu_ctrl
    import ram_lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_byte_en,
    input  logic [31:0]           ram_rd_data
);

    localparam int unsigned     CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY);

    lsu_state_t       state;
    logic             lat_we;
    logic [1:0]       lat_off;
    logic [2:0]       lat_f3;
    logic [31:0]      lat_wdata;
    logic [CNT_W-1:0] wait_cnt;

    logic             in_window;
    logic             acc_err;
    logic [31:0]      load_result;
    logic [3:0]       store_be;

    // The window is aligned to its size, so comparing the bits above the RAM span suffices.
    assign in_window = (req_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign acc_err   = f3_illegal(req_we, req_funct3) || !in_window
                     || misaligned(req_funct3, req_addr[1:0]);
    assign req_ready = (state == ST_IDLE);

    ram_lsu_ctrl_load_align u_load_align (
        .rd_data  (ram_rd_data),
        .byte_off (lat_off),
        .funct3   (lat_f3),
        .result   (load_result)
    );

    // Store lane replication and byte enables; the strobe only fires in ACCESS and never under reset.
    always_comb begin
        ram_wr_data = lat_wdata;
        store_be    = 4'b1111;
        case (lat_f3)
            F3_B: begin
                ram_wr_data = {4{lat_wdata[7:0]}};
                store_be    = 4'b0001 << lat_off;
            end
            F3_H: begin
                ram_wr_data = {2{lat_wdata[15:0]}};
                store_be    = lat_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ram_wr_data = lat_wdata;
                store_be    = 4'b1111;
            end
        endcase
        ram_wr_en      = 1'b0;
        ram_wr_byte_en = 4'b0000;
        if ((state == ST_ACCESS) && lat_we && !rst) begin
            ram_wr_en      = 1'b1;
            ram_wr_byte_en = store_be;
        end
    end

    // Request sequencing: accept/check, one RAM cycle, optional read wait, then hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            lat_we    <= 1'b0;
            lat_off   <= '0;
            lat_f3    <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_off   <= req_addr[1:0];
                        lat_f3    <= req_funct3;
                        lat_wdata <= req_wdata;
                        if (acc_err) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state    <= ST_ACCESS;
                            ram_addr <= req_addr[ADDR_WIDTH+1:2];
                        end
                    end
                end
                ST_ACCESS: begin
                    if (lat_we) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_result;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Bench for ram_lsu_ctrl: two instances (read latency 1 and 2), each with its own RAM model.
// Latency: not applicable.
// Backpressure: the bench drives rsp_ready, including a long stall.
module tb_ram_lsu_ctrl;
    import ram_lsu_ctrl_pkg::*;

    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] TOP  = 32'h0002_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid0, req_valid1, req_we, rsp_ready;
    logic [31:0]   req_addr, req_wdata;
    logic [2:0]    req_funct3;
    logic          req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [31:0]   rsp_rdata0, rsp_rdata1;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [31:0]   ram_wr_data0, ram_wr_data1, ram_rd_data0, ram_rd_data1, rd1_stage;
    logic          ram_wr_en0, ram_wr_en1;
    logic [3:0]    ram_be0, ram_be1;
    logic          mem_clr;

    ram_lsu_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .ram_addr(ram_addr0), .ram_wr_data(ram_wr_data0), .ram_wr_en(ram_wr_en0),
        .ram_wr_byte_en(ram_be0), .ram_rd_data(ram_rd_data0)
    );

    ram_lsu_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RD_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .ram_addr(ram_addr1), .ram_wr_data(ram_wr_data1), .ram_wr_en(ram_wr_en1),
        .ram_wr_byte_en(ram_be1), .ram_rd_data(ram_rd_data1)
    );

    // RAM models: byte-enabled writes, synchronous read (second one with an output register).
    logic [31:0] mem0 [0:(1<<AW)-1];
    logic [31:0] mem1 [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_en0 && ram_be0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wr_data0[8*b +: 8];
                if (ram_wr_en1 && ram_be1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wr_data1[8*b +: 8];
            end
        end
        ram_rd_data0 <= mem0[ram_addr0];
        rd1_stage    <= mem1[ram_addr1];
        ram_rd_data1 <= rd1_stage;
    end

    // Write-strobe monitor: counts strobes and remembers the last write's lanes.
    int            wr_cnt = 0;
    logic [3:0]    last_be;
    logic [31:0]   last_wd;
    logic [AW-1:0] last_wa;
    always @(negedge clk) begin
        if (ram_wr_en0) begin
            wr_cnt <= wr_cnt + 1; last_be <= ram_be0; last_wd <= ram_wr_data0; last_wa <= ram_addr0;
        end else if (ram_wr_en1) begin
            wr_cnt <= wr_cnt + 1; last_be <= ram_be1; last_wd <= ram_wr_data1; last_wa <= ram_addr1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory per instance, rules applied with plain arithmetic.
    logic [7:0] ref_mem [0:1][0:65535];

    task automatic model(input bit which, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat);
        int size;
        int off;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = 1'b0;
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) err = 1'b1;
        if (addr < BASE || addr >= TOP) err = 1'b1;
        if ((addr % size) != 0) err = 1'b1;
        rd  = '0;
        lat = 1;
        if (!err) begin
            off = int'(addr - BASE);
            lat = we ? 2 : (which ? 4 : 3);
            for (int i = 0; i < size; i++) begin
                if (we) ref_mem[which][off+i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = ref_mem[which][off+i];
            end
            if (!we && !f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
        end
    endtask

    // One complete transaction: request, wait for response, handshake it.
    task automatic xact(input bit which, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat, output int wrs);
        int n;
        int w0;
        @(negedge clk);
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd; rsp_ready = 1'b0;
        if (which) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        n = 0;
        while (!(which ? req_ready1 : req_ready0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        lat = 1;
        while (!(which ? rsp_valid1 : rsp_valid0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        err = which ? rsp_err1 : rsp_err0;
        rd  = which ? rsp_rdata1 : rsp_rdata0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wrs = wr_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_wrs;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdat;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        logic        e_err, r_err;
        logic [31:0] e_rd, r_rd;
        int          e_lat, r_lat, r_wrs, n, w0;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        bit          which;

        tbl[0]  = '{1'b1, 32'h0001_0008, F3_W,  32'hDEAD_BEEF, 1'b0, 32'h0,         2, 1, 4'hF, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b1, 32'h0001_0003, F3_B,  32'h0000_00A5, 1'b0, 32'h0,         2, 1, 4'h8, 32'hA5A5_A5A5};
        tbl[2]  = '{1'b0, 32'h0001_0003, F3_B,  32'h0,         1'b0, 32'hFFFF_FFA5, 3, 0, 4'h0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0001_0003, F3_BU, 32'h0,         1'b0, 32'h0000_00A5, 3, 0, 4'h0, 32'h0};
        tbl[4]  = '{1'b1, 32'h0001_0006, F3_H,  32'h0000_8001, 1'b0, 32'h0,         2, 1, 4'hC, 32'h8001_8001};
        tbl[5]  = '{1'b0, 32'h0001_0006, F3_H,  32'h0,         1'b0, 32'hFFFF_8001, 3, 0, 4'h0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0001_0006, F3_HU, 32'h0,         1'b0, 32'h0000_8001, 3, 0, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0001_0007, F3_B,  32'h0,         1'b0, 32'hFFFF_FF80, 3, 0, 4'h0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0001_0006, F3_BU, 32'h0,         1'b0, 32'h0000_0001, 3, 0, 4'h0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0001_0008, F3_W,  32'h0,         1'b0, 32'hDEAD_BEEF, 3, 0, 4'h0, 32'h0};
        tbl[10] = '{1'b0, 32'h0001_0002, F3_W,  32'h0,         1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h0001_0001, F3_H,  32'h0,         1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[12] = '{1'b1, 32'h0002_0000, F3_W,  32'h1234_5678, 1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[13] = '{1'b0, 32'h0000_FFFC, F3_W,  32'h0,         1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[14] = '{1'b0, 32'h0001_0000, 3'd3,  32'h0,         1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[15] = '{1'b1, 32'h0001_0000, F3_BU, 32'h0000_0011, 1'b1, 32'h0,         1, 0, 4'h0, 32'h0};
        tbl[16] = '{1'b1, 32'h0001_FFFC, F3_W,  32'h1122_3344, 1'b0, 32'h0,         2, 1, 4'hF, 32'h1122_3344};
        tbl[17] = '{1'b0, 32'h0001_FFFC, F3_W,  32'h0,         1'b0, 32'h1122_3344, 3, 0, 4'h0, 32'h0};
        tbl[18] = '{1'b1, 32'h0001_0000, F3_B,  32'hFFFF_FF5A, 1'b0, 32'h0,         2, 1, 4'h1, 32'h5A5A_5A5A};
        tbl[19] = '{1'b0, 32'h0001_0000, F3_W,  32'h0,         1'b0, 32'hA500_005A, 3, 0, 4'h0, 32'h0};

        for (int i = 0; i < 65536; i++) begin
            ref_mem[0][i] = 8'h00;
            ref_mem[1][i] = 8'h00;
        end

        // Reset and RAM clear
        rst = 1'b1; mem_clr = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_wr_en", {31'b0, ram_wr_en0}, 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid0}, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err0}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata0, 32'd0);
        chk("reset_ram_addr", {18'b0, ram_addr0}, 32'd0);
        chk("reset_req_ready", {31'b0, req_ready0}, 32'd1);
        chk("reset_rsp_valid_l2", {31'b0, rsp_valid1}, 32'd0);

        // Directed vectors on the latency-1 instance
        for (int i = 0; i < NV; i++) begin
            model(1'b0, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, e_err, e_rd, e_lat);
            xact(1'b0, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, r_err, r_rd, r_lat, r_wrs);
            chk($sformatf("v%0d_err", i), {31'b0, r_err}, {31'b0, tbl[i].exp_err});
            chk($sformatf("v%0d_rdata", i), r_rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_latency", i), r_lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_wr_count", i), r_wrs, tbl[i].exp_wrs);
            if (tbl[i].exp_wrs == 1) begin
                chk($sformatf("v%0d_be", i), {28'b0, last_be}, {28'b0, tbl[i].exp_be});
                chk($sformatf("v%0d_wr_data", i), last_wd, tbl[i].exp_wdat);
                chk($sformatf("v%0d_ram_addr", i), {18'b0, last_wa}, {18'b0, tbl[i].addr[15:2]});
            end
        end

        // Read latency 2: SH then LH
        model(1'b1, 1'b1, 32'h0001_0006, F3_H, 32'h0000_8001, e_err, e_rd, e_lat);
        xact(1'b1, 1'b1, 32'h0001_0006, F3_H, 32'h0000_8001, r_err, r_rd, r_lat, r_wrs);
        chk("l2_sh_latency", r_lat, 32'd2);
        chk("l2_sh_be", {28'b0, last_be}, 32'hC);
        model(1'b1, 1'b0, 32'h0001_0006, F3_H, 32'h0, e_err, e_rd, e_lat);
        xact(1'b1, 1'b0, 32'h0001_0006, F3_H, 32'h0, r_err, r_rd, r_lat, r_wrs);
        chk("l2_lh_rdata", r_rd, 32'hFFFF_8001);
        chk("l2_lh_latency", r_lat, 32'd4);

        // Stall with a queued store behind a load
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h0001_0008; req_funct3 = F3_W; req_valid0 = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0001_000C; req_funct3 = F3_W; req_wdata = 32'h1234_5678;
        n = 0;
        while (!rsp_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_load_latency", n, 32'd2);
        w0 = wr_cnt;
        repeat (5) begin
            chk("stall_rsp_valid", {31'b0, rsp_valid0}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata0, 32'hDEAD_BEEF);
            chk("stall_rsp_err", {31'b0, rsp_err0}, 32'd0);
            chk("stall_req_ready", {31'b0, req_ready0}, 32'd0);
            @(negedge clk);
        end
        chk("stall_no_early_write", wr_cnt - w0, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("queued_req_ready", {31'b0, req_ready0}, 32'd1);
        chk("queued_rsp_dropped", {31'b0, rsp_valid0}, 32'd0);
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("queued_wr_en", {31'b0, ram_wr_en0}, 32'd1);
        chk("queued_ram_addr", {18'b0, ram_addr0}, 32'd3);
        n = 1;
        while (!rsp_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queued_latency", n, 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model(1'b0, 1'b1, 32'h0001_000C, F3_W, 32'h1234_5678, e_err, e_rd, e_lat);
        xact(1'b0, 1'b0, 32'h0001_000C, F3_W, 32'h0, r_err, r_rd, r_lat, r_wrs);
        chk("queued_readback", r_rd, 32'h1234_5678);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0001_0010; req_funct3 = F3_W; req_wdata = 32'hCAFE_F00D; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_access_wr_en", {31'b0, ram_wr_en0}, 32'd0);
        chk("rst_access_be", {28'b0, ram_be0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_access_rsp_valid", {31'b0, rsp_valid0}, 32'd0);
        chk("rst_access_req_ready", {31'b0, req_ready0}, 32'd1);
        chk("rst_access_ram_word", mem0[4], 32'd0);
        xact(1'b0, 1'b0, 32'h0001_0010, F3_W, 32'h0, r_err, r_rd, r_lat, r_wrs);
        chk("rst_access_readback", r_rd, 32'd0);

        // Randomized traffic on both instances against the reference model
        for (int k = 0; k < 400; k++) begin
            which = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            if (we && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       addr = $urandom();
                1:       addr = TOP - 32'd4 + 32'($urandom_range(0, 7));
                2:       addr = BASE - 32'd4 + 32'($urandom_range(0, 7));
                default: addr = BASE + 32'($urandom_range(0, 63));
            endcase
            wd = $urandom();
            model(which, we, addr, f3, wd, e_err, e_rd, e_lat);
            xact(which, we, addr, f3, wd, r_err, r_rd, r_lat, r_wrs);
            chk($sformatf("rnd%0d_err", k), {31'b0, r_err}, {31'b0, e_err});
            chk($sformatf("rnd%0d_rdata", k), r_rd, e_rd);
            chk($sformatf("rnd%0d_latency", k), r_lat, e_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
